// File: rtl/sp_ram_pkg.sv
// rtl/sp_ram_pkg.sv - mode constants and FSM state type for sp_ram_ctl
package sp_ram_pkg;

  localparam int WM_NORMAL        = 0;
  localparam int WM_WRITE_THROUGH = 1;
  localparam int WM_READ_FIRST    = 2;

  localparam int RM_BYPASS   = 0;
  localparam int RM_PIPELINE = 1;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

endpackage

// File: rtl/sp_ram_array.sv
// rtl/sp_ram_array.sv - raw single-port storage, one write port and one registered read port
// No reset anywhere so synthesis can map it onto block RAM.
module sp_ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Read sees the pre-write word on a same-edge write (read-first port).
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sp_ram_ctl.sv
// rtl/sp_ram_ctl.sv - single-port RAM controller: clear sweep, write modes, optional output register
// Stage 1 is either the RAM read register or a local hold register, picked by use_ram_q.
module sp_ram_ctl
  import sp_ram_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int READ_MODE  = 0,
  parameter int WRITE_MODE = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              oce,
  input  logic              wre,
  input  logic [ADDR_W-1:0] ad,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  output logic [DATA_W-1:0] dout,
  output logic              busy
);

  localparam state_t            RST_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic [ADDR_W-1:0] CNT_LAST  = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              use_ram_q, use_ram_d;
  logic [DATA_W-1:0] out_q;
  logic              clr_hit;
  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] stage1;

  sp_ram_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .re   (arr_re),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RST_STATE;
      cnt_q     <= '0;
      hold_q    <= '0;
      use_ram_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      use_ram_q <= use_ram_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    use_ram_d = use_ram_q;
    clr_hit   = 1'b0;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = ad;
    arr_wdata = din;
    case (state_q)
      ST_CLEAR: begin
        arr_we    = 1'b1;
        arr_addr  = cnt_q;
        arr_wdata = '0;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        // clr wins over a same-cycle access, which is dropped entirely.
        if (clr) begin
          state_d   = ST_CLEAR;
          cnt_d     = '0;
          hold_d    = '0;
          use_ram_d = 1'b0;
          clr_hit   = 1'b1;
        end else if (ce) begin
          if (wre) begin
            arr_we = 1'b1;
            case (WRITE_MODE)
              WM_WRITE_THROUGH: begin
                hold_d    = din;
                use_ram_d = 1'b0;
              end
              WM_READ_FIRST: begin
                arr_re    = 1'b1;
                use_ram_d = 1'b1;
              end
              default: ;
            endcase
          end else begin
            arr_re    = 1'b1;
            use_ram_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign stage1 = use_ram_q ? ram_q : hold_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
    end else if (clr_hit) begin
      out_q <= '0;
    end else if (oce) begin
      out_q <= stage1;
    end
  end

  assign dout = (READ_MODE == RM_PIPELINE) ? out_q : stage1;
  assign busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_sp_ram_ctl.sv
// tb/tb_sp_ram_ctl.sv - table-driven bench for sp_ram_ctl across read and write modes
module tb_sp_ram_ctl;

  logic       clk;
  logic       reset_n;
  logic       ce, oce, wre, clr;
  logic [1:0] ad;
  logic [7:0] din;
  logic [7:0] dout_a, dout_b, dout_c, dout_p, dout_e;
  logic       busy_a, busy_b, busy_c, busy_p, busy_e;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       rst;
    logic       clr, ce, wre;
    logic [1:0] ad;
    logic [7:0] din;
    logic       oce;
    logic       busy;
    logic [7:0] da, db, dc, dp;
  } vec_t;

  vec_t vecs[$];

  sp_ram_ctl #(.DATA_W(8), .ADDR_W(2), .READ_MODE(0), .WRITE_MODE(0), .INIT_CLEAR(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .clr(clr), .dout(dout_a), .busy(busy_a));
  sp_ram_ctl #(.DATA_W(8), .ADDR_W(2), .READ_MODE(0), .WRITE_MODE(1), .INIT_CLEAR(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .clr(clr), .dout(dout_b), .busy(busy_b));
  sp_ram_ctl #(.DATA_W(8), .ADDR_W(2), .READ_MODE(0), .WRITE_MODE(2), .INIT_CLEAR(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .clr(clr), .dout(dout_c), .busy(busy_c));
  sp_ram_ctl #(.DATA_W(8), .ADDR_W(2), .READ_MODE(1), .WRITE_MODE(0), .INIT_CLEAR(1)) dut_p (
    .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .clr(clr), .dout(dout_p), .busy(busy_p));
  sp_ram_ctl #(.DATA_W(8), .ADDR_W(2), .READ_MODE(0), .WRITE_MODE(0), .INIT_CLEAR(0)) dut_e (
    .clk(clk), .reset_n(reset_n), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din),
    .clr(clr), .dout(dout_e), .busy(busy_e));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no summary, expected summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic c_clr, input logic c_ce,
                              input logic c_wre, input logic [1:0] c_ad, input logic [7:0] c_din,
                              input logic c_oce, input logic e_busy, input logic [7:0] e_a,
                              input logic [7:0] e_b, input logic [7:0] e_c, input logic [7:0] e_p);
    vec_t v;
    v.rst = rst; v.clr = c_clr; v.ce = c_ce; v.wre = c_wre; v.ad = c_ad; v.din = c_din;
    v.oce = c_oce; v.busy = e_busy; v.da = e_a; v.db = e_b; v.dc = e_c; v.dp = e_p;
    vecs.push_back(v);
  endfunction

  // Drive just after a falling edge, check 1 time unit after the next rising edge.
  task automatic apply(input vec_t v, input int idx);
    reset_n = v.rst; clr = v.clr; ce = v.ce; wre = v.wre; ad = v.ad; din = v.din; oce = v.oce;
    @(posedge clk);
    #1;
    check($sformatf("v%0d busy", idx), {7'd0, busy_a}, {7'd0, v.busy});
    check($sformatf("v%0d busy_p", idx), {7'd0, busy_p}, {7'd0, v.busy});
    check($sformatf("v%0d dout wm0", idx), dout_a, v.da);
    check($sformatf("v%0d dout wm1", idx), dout_b, v.db);
    check($sformatf("v%0d dout wm2", idx), dout_c, v.dc);
    check($sformatf("v%0d dout pipe", idx), dout_p, v.dp);
    @(negedge clk);
  endtask

  initial begin
    //  rst clr ce wre ad din   oce   busy  wm0    wm1    wm2    pipe
    // power-up sweep: busy 4 cycles, accesses during it are ignored
    add(1, 0, 0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 0, 1, 1, 0, 8'h99, 1,   1, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 0, 1, 0, 1, 8'h00, 1,   1, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 0, 0, 0, 0, 8'h00, 1,   0, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int a = 0; a < 4; a++)
      add(1, 0, 1, 0, 2'(a), 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    // writes, then bypass and pipeline reads with an oce gap
    add(1, 0, 1, 1, 1, 8'hA5, 1,   0, 8'h00, 8'hA5, 8'h00, 8'h00);
    add(1, 0, 1, 1, 2, 8'h3C, 1,   0, 8'h00, 8'h3C, 8'h00, 8'h00);
    add(1, 0, 1, 0, 1, 8'h00, 1,   0, 8'hA5, 8'hA5, 8'hA5, 8'h00);
    add(1, 0, 0, 0, 0, 8'h00, 1,   0, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    add(1, 0, 1, 0, 2, 8'h00, 0,   0, 8'h3C, 8'h3C, 8'h3C, 8'hA5);
    add(1, 0, 0, 0, 0, 8'h00, 0,   0, 8'h3C, 8'h3C, 8'h3C, 8'hA5);
    add(1, 0, 0, 0, 0, 8'h00, 1,   0, 8'h3C, 8'h3C, 8'h3C, 8'h3C);
    add(1, 0, 1, 0, 1, 8'h00, 1,   0, 8'hA5, 8'hA5, 8'hA5, 8'h3C);
    add(1, 0, 1, 0, 2, 8'h00, 1,   0, 8'h3C, 8'h3C, 8'h3C, 8'hA5);
    add(1, 0, 0, 0, 0, 8'h00, 1,   0, 8'h3C, 8'h3C, 8'h3C, 8'h3C);
    // write modes on address 3
    add(1, 0, 1, 1, 3, 8'h11, 1,   0, 8'h3C, 8'h11, 8'h00, 8'h3C);
    add(1, 0, 1, 0, 1, 8'h00, 1,   0, 8'hA5, 8'hA5, 8'hA5, 8'h3C);
    add(1, 0, 1, 1, 3, 8'h22, 1,   0, 8'hA5, 8'h22, 8'h11, 8'hA5);
    add(1, 0, 1, 0, 3, 8'h00, 1,   0, 8'h22, 8'h22, 8'h22, 8'hA5);
    add(1, 0, 0, 0, 0, 8'h00, 1,   0, 8'h22, 8'h22, 8'h22, 8'h22);
    // clr with a same-cycle write, ignored read and repeated clr mid-sweep
    add(1, 1, 1, 1, 0, 8'h77, 1,   1, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 0, 1, 0, 1, 8'h00, 1,   1, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 1, 0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 0, 0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 0, 0, 0, 0, 8'h00, 1,   0, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int a = 0; a < 4; a++)
      add(1, 0, 1, 0, 2'(a), 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    // fill 2..3 with FF, start a sweep and abort it with reset at cycle 2
    add(1, 0, 1, 1, 2, 8'hFF, 1,   0, 8'h00, 8'hFF, 8'h00, 8'h00);
    add(1, 0, 1, 1, 3, 8'hFF, 1,   0, 8'h00, 8'hFF, 8'h00, 8'h00);
    add(1, 0, 1, 0, 2, 8'h00, 1,   0, 8'hFF, 8'hFF, 8'hFF, 8'h00);
    add(1, 0, 0, 0, 0, 8'h00, 1,   0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    add(1, 1, 0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 0, 0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 0, 0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 0, 0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 0, 0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 0, 0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 0, 0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 0, 0, 0, 0, 8'h00, 1,   0, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int a = 0; a < 4; a++)
      add(1, 0, 1, 0, 2'(a), 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00);

    reset_n = 1'b0; clr = 1'b0; ce = 1'b0; wre = 1'b0; ad = 2'd0; din = 8'h00; oce = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset busy init_clear=1", {7'd0, busy_a}, 8'h01);
    check("reset busy init_clear=0", {7'd0, busy_e}, 8'h00);
    check("reset dout bypass", dout_a, 8'h00);
    check("reset dout pipe", dout_p, 8'h00);
    check("reset dout init_clear=0", dout_e, 8'h00);

    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("release busy init_clear=1", {7'd0, busy_a}, 8'h01);
    check("release busy init_clear=0", {7'd0, busy_e}, 8'h00);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
